kbd_text_writer: RTL
====================

Name: kbd_text_writer

Overview:
Consumes the byte stream from the PS/2 receiver and drives the write port of the 64-byte character RAM that the LCD12864 controller scans. Decodes make, break (F0) and extended (E0) sequences and tracks Shift state. Maintains a cursor and converts printable keys to ASCII. Handles Backspace, Enter and Esc, and blanks the whole buffer after reset.

Parameters:
COLS, 16, characters per LCD line
ROWS, 4, LCD lines; COLS*ROWS must equal 2**ADDR_W
ADDR_W, 6, RAM address width
BLANK, 8'h20, fill character used by clear and backspace

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
scan_done_tick  in  1  one-cycle strobe from the PS/2 receiver; scan_data is valid in that cycle
scan_data  in  8  received PS/2 byte
we  out  1  RAM write enable, registered
write_address  out  ADDR_W  RAM write address, registered
ram_in  out  8  RAM write data, registered
cursor  out  ADDR_W  next write position
busy  out  1  high while a clear sweep is running

Behaviour:
- Reset (reset=0, asynchronous) drives these values:
  - we=0, write_address=0, ram_in=BLANK, cursor=0
  - shift_l=0, shift_r=0, brk_flag=0, ext_flag=0
  - state=CLEAR, clr_cnt=0, busy=1
- States: CLEAR, IDLE.
- CLEAR:
  - Each cycle registers we=1, write_address=clr_cnt, ram_in=BLANK, then increments clr_cnt.
  - On the first clock edge after reset deassertion, we=1 with address 0. we stays high for exactly 64 consecutive cycles, covering addresses 0..63.
  - After address 63, the next state is IDLE with we=0, busy=0, cursor=0.
  - scan_done_tick is ignored during CLEAR. Flags are not updated.
- IDLE: on scan_done_tick the byte is decoded. Any resulting write appears as a one-cycle we pulse in the cycle after the tick (latency 1). With no tick, we=0.
- Decode priority, evaluated on scan_data with the current flags:
  1. 8'hE0: set ext_flag. No write.
  2. 8'hF0: set brk_flag. No write.
  3. ext_flag=1: byte ignored (arrows, keypad Enter, right Ctrl/Alt, E0 12). Clear ext_flag and brk_flag.
  4. brk_flag=1: on 8'h12 clear shift_l; on 8'h59 clear shift_r; otherwise no action. Clear brk_flag. Never writes.
  5. 8'h12: set shift_l. 8'h59: set shift_r. No write.
  6. 8'h66 (Backspace):
     - If cursor>0: cursor-=1 and write BLANK at the new cursor.
     - If cursor=0: no write, cursor stays 0 (saturates).
  7. 8'h5A (Enter): cursor = (cursor/COLS + 1)*COLS mod 64. From the last line this wraps to 0. No write.
  8. 8'h76 (Esc): enter CLEAR with clr_cnt=0 (64-cycle sweep, busy=1). Shift flags are kept; cursor ends at 0.
  9. Otherwise: ascii = lut(scan_data, shift_l|shift_r).
     - If ascii != 8'h00: write ascii at cursor, then cursor+=1 mod 64 (63 wraps to 0).
     - If ascii = 8'h00 (unmapped): no write.
- Typematic repeats of a held key arrive as repeated make codes. Each one writes.
- Arithmetic: cursor is ADDR_W bits unsigned. All wrap is modulo 2**ADDR_W.
- The write_address and ram_in registers hold their last value while we=0.

Decomposition:
- Shared package kbd_pkg:
  - Scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_BKSP=66, SC_ENTER=5A, SC_ESC=76
  - BLANK
  - State encoding: CLEAR, IDLE
- Sub-module kbd_ascii_lut: purely combinational, shift-aware scan-code-to-ASCII table.
  - Unshifted: letters lowercase, digits, space, punctuation.
  - Shifted: uppercase letters and shifted symbols.
  - Returns 8'h00 when unmapped.

Test Plan:
- Reset low 3 cycles, release -> we=1 for exactly 64 cycles, addresses 0..63 in order, data 8'h20; then busy=0, cursor=0.
- Ticks 1C, F0, 1C -> one write, addr 0, data 8'h61, one cycle after the first tick; cursor=1; break sequence produces no write.
- Ticks 12, 1C, F0, 12, 1C -> writes 8'h41 at addr 0, then 8'h61 at addr 1; cursor=2.
- Type 5 chars, tick 5A, tick 66 -> cursor 5 -> 16 -> 15; write 8'h20 at addr 15. At cursor=0, tick 66 -> no write, cursor stays 0.
- Fill to cursor=63, type 8'h1C -> write at 63, cursor=0. Cursor at 50, tick 5A -> cursor=0. Ticks E0, 75 and E0, F0, 75 -> no write, cursor unchanged.
- Tick 76 mid-text -> 64-cycle BLANK sweep, busy=1, cursor=0. A tick 1C injected during the sweep is ignored: no extra write after the sweep.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard text writer.
// Scan codes are PS/2 set 2.
package kbd_pkg;

  localparam int COLS   = 16;
  localparam int ROWS   = 4;
  localparam int ADDR_W = 6;

  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_ESC    = 8'h76;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  function automatic logic [7:0] pick(
    input logic       s,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    return s ? hi : lo;
  endfunction

endpackage

// File: rtl/kbd_ascii_lut.sv
// Shift-aware PS/2 set-2 scan code to ASCII table.
// Unmapped codes return 8'h00.
module kbd_ascii_lut
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = pick(shift, "a", "A");
      8'h32: ascii = pick(shift, "b", "B");
      8'h21: ascii = pick(shift, "c", "C");
      8'h23: ascii = pick(shift, "d", "D");
      8'h24: ascii = pick(shift, "e", "E");
      8'h2B: ascii = pick(shift, "f", "F");
      8'h34: ascii = pick(shift, "g", "G");
      8'h33: ascii = pick(shift, "h", "H");
      8'h43: ascii = pick(shift, "i", "I");
      8'h3B: ascii = pick(shift, "j", "J");
      8'h42: ascii = pick(shift, "k", "K");
      8'h4B: ascii = pick(shift, "l", "L");
      8'h3A: ascii = pick(shift, "m", "M");
      8'h31: ascii = pick(shift, "n", "N");
      8'h44: ascii = pick(shift, "o", "O");
      8'h4D: ascii = pick(shift, "p", "P");
      8'h15: ascii = pick(shift, "q", "Q");
      8'h2D: ascii = pick(shift, "r", "R");
      8'h1B: ascii = pick(shift, "s", "S");
      8'h2C: ascii = pick(shift, "t", "T");
      8'h3C: ascii = pick(shift, "u", "U");
      8'h2A: ascii = pick(shift, "v", "V");
      8'h1D: ascii = pick(shift, "w", "W");
      8'h22: ascii = pick(shift, "x", "X");
      8'h35: ascii = pick(shift, "y", "Y");
      8'h1A: ascii = pick(shift, "z", "Z");
      8'h45: ascii = pick(shift, "0", ")");
      8'h16: ascii = pick(shift, "1", "!");
      8'h1E: ascii = pick(shift, "2", "@");
      8'h26: ascii = pick(shift, "3", "#");
      8'h25: ascii = pick(shift, "4", "$");
      8'h2E: ascii = pick(shift, "5", "%");
      8'h36: ascii = pick(shift, "6", "^");
      8'h3D: ascii = pick(shift, "7", "&");
      8'h3E: ascii = pick(shift, "8", "*");
      8'h46: ascii = pick(shift, "9", "(");
      8'h29: ascii = " ";
      8'h0E: ascii = pick(shift, 8'h60, "~");
      8'h4E: ascii = pick(shift, "-", "_");
      8'h55: ascii = pick(shift, "=", "+");
      8'h54: ascii = pick(shift, "[", "{");
      8'h5B: ascii = pick(shift, "]", "}");
      8'h5D: ascii = pick(shift, "\\", "|");
      8'h4C: ascii = pick(shift, ";", ":");
      8'h52: ascii = pick(shift, "'", "\"");
      8'h41: ascii = pick(shift, ",", "<");
      8'h49: ascii = pick(shift, ".", ">");
      8'h4A: ascii = pick(shift, "/", "?");
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/kbd_text_writer.sv
// PS/2 byte stream to character-RAM writer with cursor,
// shift tracking, backspace/enter/esc and power-on clear.
module kbd_text_writer
  import kbd_pkg::*;
#(
  parameter int         COLS_P   = COLS,
  parameter int         ROWS_P   = ROWS,
  parameter int         ADDR_W_P = ADDR_W,
  parameter logic [7:0] BLANK_P  = BLANK
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scan_done_tick,
  input  logic [7:0]          scan_data,
  output logic                we,
  output logic [ADDR_W_P-1:0] write_address,
  output logic [7:0]          ram_in,
  output logic [ADDR_W_P-1:0] cursor,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [ADDR_W_P-1:0] clr_cnt_q, clr_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W_P-1:0] addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [ADDR_W_P-1:0] cursor_q, cursor_d;
  logic                shift_l_q, shift_l_d;
  logic                shift_r_q, shift_r_d;
  logic                brk_q, brk_d;
  logic                ext_q, ext_d;
  logic                busy_q, busy_d;

  logic [7:0]          ascii;
  int                  row;

  kbd_ascii_lut u_lut (
    .code  (scan_data),
    .shift (shift_l_q | shift_r_q),
    .ascii (ascii)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    cursor_d  = cursor_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    busy_d    = busy_q;
    row       = int'(cursor_q) / COLS_P;
    unique case (state_q)
      ST_CLEAR: begin
        we_d      = 1'b1;
        addr_d    = clr_cnt_q;
        data_d    = BLANK_P;
        clr_cnt_d = clr_cnt_q + 1'b1;
        cursor_d  = '0;
        busy_d    = 1'b1;
        if (clr_cnt_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        busy_d = 1'b0;
        if (scan_done_tick) begin
          priority case (1'b1)
            scan_data == SC_EXT: ext_d = 1'b1;
            scan_data == SC_BRK: brk_d = 1'b1;
            ext_q: begin
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
            brk_q: begin
              brk_d = 1'b0;
              if (scan_data == SC_LSHIFT) shift_l_d = 1'b0;
              if (scan_data == SC_RSHIFT) shift_r_d = 1'b0;
            end
            scan_data == SC_LSHIFT: shift_l_d = 1'b1;
            scan_data == SC_RSHIFT: shift_r_d = 1'b1;
            scan_data == SC_BKSP: begin
              if (cursor_q != '0) begin
                cursor_d = cursor_q - 1'b1;
                we_d     = 1'b1;
                addr_d   = cursor_q - 1'b1;
                data_d   = BLANK_P;
              end
            end
            scan_data == SC_ENTER:
              cursor_d = ADDR_W_P'(((row + 1) % ROWS_P) * COLS_P);
            scan_data == SC_ESC: begin
              state_d   = ST_CLEAR;
              clr_cnt_d = '0;
              busy_d    = 1'b1;
            end
            default: begin
              if (ascii != 8'h00) begin
                we_d     = 1'b1;
                addr_d   = cursor_q;
                data_d   = ascii;
                cursor_d = cursor_q + 1'b1;
              end
            end
          endcase
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= BLANK_P;
      cursor_q  <= '0;
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cursor_q  <= cursor_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      busy_q    <= busy_d;
    end
  end

  assign we            = we_q;
  assign write_address = addr_q;
  assign ram_in        = data_q;
  assign cursor        = cursor_q;
  assign busy          = busy_q;

endmodule
